// File: rtl/i1_rr_scheduler.sv
// i1_rr_scheduler
// Round-robin scheduler that shares the i1 encode/decode datapath among
// NREQ request lines. One requester holds the datapath until it signals
// done, drops its request, enable falls, or (optionally) the hold timer
// expires. Each grant is followed by a one-cycle release bubble.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       global qualifier; low blocks new grants and forces release
//   req          level request per requester (bit 0 = requester 0)
//   done         granted requester finished this cycle (ignored outside GRANT)
//   grant        registered one-hot grant
//   grant_valid  registered, equals |grant
//   grant_id     registered binary index of the granted requester, 0 if none
//   idle         combinational enable & (req == 0)
//   timeout      registered one-cycle pulse when a grant is forcibly ended
//
// Optional feature macro: I1_SCHED_TIMEOUT_EN
//   defined   -> hold counter built; a grant lasts at most HOLD_MAX+1 cycles
//   undefined -> no counter, timeout tied low, HOLD_MAX unused
//
// state   | meaning
// IDLE    | no grant; waits for enable & |req
// ARB     | one cycle: round-robin pick after ptr, register the grant
// GRANT   | grant held until done / request drop / enable low / timeout
// RELEASE | one-cycle bubble with grant cleared; ptr updated

module i1_rr_scheduler #(
  parameter int NREQ     = 7,
  parameter int HOLD_MAX = 15,
  parameter int IDW      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id,
  output logic            idle,
  output logic            timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_RELEASE} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] grant_nx;
  logic [IDW-1:0]  grant_id_nx;
  logic            grant_valid_nx;
  logic [IDW-1:0]  ptr, ptr_nx;
  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic            own_req;
  logic            hold_hit;

`ifdef I1_SCHED_TIMEOUT_EN
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  logic [CW-1:0] count, count_nx;
  logic          timeout_nx;
  assign hold_hit = (count == CW'(HOLD_MAX));
`else
  assign hold_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign idle    = enable & (req == '0);
  // grant is one-hot, so this is req[grant_id] without a variable index
  assign own_req = |(req & grant);

  // Round-robin pick: first set bit above ptr, then wrap to bits 0..ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!pick_found && req[j] && (j > int'(ptr))) begin
        pick_found = 1'b1;
        pick_id    = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!pick_found && req[j] && (j <= int'(ptr))) begin
        pick_found = 1'b1;
        pick_id    = IDW'(j);
      end
    end
  end

  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    grant_id_nx    = grant_id;
    grant_valid_nx = grant_valid;
    ptr_nx         = ptr;
`ifdef I1_SCHED_TIMEOUT_EN
    count_nx       = count;
    timeout_nx     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        grant_nx       = '0;
        grant_id_nx    = '0;
        grant_valid_nx = 1'b0;
        if (enable && (req != '0)) state_nx = S_ARB;
      end
      S_ARB: begin
        if (enable && pick_found) begin
          grant_nx       = {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
          grant_id_nx    = pick_id;
          grant_valid_nx = 1'b1;
`ifdef I1_SCHED_TIMEOUT_EN
          count_nx       = '0;
`endif
          state_nx       = S_GRANT;
        end else begin
          grant_nx       = '0;
          grant_id_nx    = '0;
          grant_valid_nx = 1'b0;
          state_nx       = S_IDLE;
        end
      end
      S_GRANT: begin
        if (done || !own_req || !enable || hold_hit) begin
          grant_nx       = '0;
          grant_id_nx    = '0;
          grant_valid_nx = 1'b0;
          ptr_nx         = grant_id;
          state_nx       = S_RELEASE;
`ifdef I1_SCHED_TIMEOUT_EN
          // done takes precedence over an expiring timer
          timeout_nx     = hold_hit && !done && own_req && enable;
`endif
        end else begin
`ifdef I1_SCHED_TIMEOUT_EN
          count_nx = count + 1'b1;
`endif
        end
      end
      S_RELEASE: begin
        grant_nx       = '0;
        grant_id_nx    = '0;
        grant_valid_nx = 1'b0;
        state_nx       = S_IDLE;
      end
      default: begin
        grant_nx       = '0;
        grant_id_nx    = '0;
        grant_valid_nx = 1'b0;
        state_nx       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      ptr         <= IDW'(NREQ - 1);
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      grant_id    <= grant_id_nx;
      grant_valid <= grant_valid_nx;
      ptr         <= ptr_nx;
    end
  end

`ifdef I1_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      count   <= count_nx;
      timeout <= timeout_nx;
    end
  end
`endif

endmodule

// File: tb/tb_i1_rr_scheduler.sv
module tb_i1_rr_scheduler;

  localparam int NREQ = 7;
  localparam int IDW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] grant;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic            idle;
  logic            timeout;

  int n_vec  = 0;
  int n_miss = 0;

  i1_rr_scheduler #(.NREQ(NREQ), .HOLD_MAX(15), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .idle(idle), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int id);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    chk_val({tag, "_grant"}, 32'(grant), 32'(oh));
    chk_val({tag, "_id"}, 32'(grant_id), 32'(id));
    chk_val({tag, "_valid"}, 32'(grant_valid), 32'd1);
  endtask

  task automatic chk_none(input string tag);
    chk_val({tag, "_grant"}, 32'(grant), 32'd0);
    chk_val({tag, "_valid"}, 32'(grant_valid), 32'd0);
    chk_val({tag, "_id"}, 32'(grant_id), 32'd0);
  endtask

  int exp_order [4] = '{2, 6, 0, 2};

  initial begin
    rst_n = 1'b0; enable = 1'b0; req = '0; done = 1'b0;
    #12;
    chk_none("reset");
    chk_val("reset_timeout", 32'(timeout), 32'd0);
    chk_val("reset_idle_en0", 32'(idle), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    #1;
    chk_val("idle_req0", 32'(idle), 32'd1);

    // single requester 0, two-cycle latency, done releases next cycle
    tick();
    req = 7'b0000001;
    #1;
    chk_val("idle_req1", 32'(idle), 32'd0);
    tick();
    chk_val("arb_no_grant", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("first", 0);
    done = 1'b1;
    tick();
    chk_none("first_rel");
    chk_val("first_rel_to", 32'(timeout), 32'd0);
    done = 1'b0;
    req = '0;
    tick();

    // rotation over requesters 2, 6, 0
    req = 7'b1000101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_val($sformatf("rr%0d_arb", k), 32'(grant_valid), 32'd0);
      tick();
      chk_grant($sformatf("rr%0d", k), exp_order[k]);
      tick();
      tick();
      done = 1'b1;
      tick();
      chk_none($sformatf("rr%0d_rel", k));
      done = 1'b0;
      if (k == 3) req = '0;
      tick();
      chk_val($sformatf("rr%0d_gap", k), 32'(grant_valid), 32'd0);
    end

    // enable drop during GRANT
    req = 7'b0001000;
    tick();
    tick();
    chk_grant("en_drop", 3);
    tick();
    enable = 1'b0;
    tick();
    chk_none("en_drop_rel");
    chk_val("en_drop_to", 32'(timeout), 32'd0);
    chk_val("idle_en0", 32'(idle), 32'd0);
    req = '0;
    enable = 1'b1;
    #1;
    chk_val("idle_back", 32'(idle), 32'd1);
    tick();

    // own request drop; ptr=3 so requester 1 is found after wrapping
    req = 7'b0000010;
    tick();
    tick();
    chk_grant("req_drop", 1);
    req = '0;
    tick();
    chk_none("req_drop_rel");
    chk_val("req_drop_to", 32'(timeout), 32'd0);
    tick();

    // long hold with done never asserted
    req = 7'b0001000;
    tick();
    tick();
    for (int c = 0; c < 16; c++) begin
      chk_val($sformatf("hold_c%0d", c), 32'(grant), 32'h08);
      if (c < 15) tick();
    end
`ifdef I1_SCHED_TIMEOUT_EN
    tick();
    chk_none("to_rel");
    chk_val("to_pulse", 32'(timeout), 32'd1);
    tick();
    chk_val("to_pulse_end", 32'(timeout), 32'd0);
    tick();
    chk_val("to_arb", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("to_regrant", 3);
    for (int c = 0; c < 15; c++) tick();
    done = 1'b1;
    tick();
    chk_none("done_at_max");
    chk_val("done_at_max_to", 32'(timeout), 32'd0);
`else
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_val($sformatf("no_to_hold%0d", c), 32'(grant), 32'h08);
      chk_val($sformatf("no_to_pulse%0d", c), 32'(timeout), 32'd0);
    end
    done = 1'b1;
    tick();
    chk_none("no_to_done");
    chk_val("no_to_done_to", 32'(timeout), 32'd0);
`endif
    done = 1'b0;
    req = '0;
    tick();

    // async reset mid-GRANT; ptr=3 so requester 4..6,0..2 order gives 2
    req = 7'b0000100;
    tick();
    tick();
    chk_grant("pre_rst", 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_none("async_rst");
    req = 7'b1111111;
    #1;
    rst_n = 1'b1;
    tick();
    chk_val("post_rst_arb", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
